// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the data bus, TX shifter, RX sampler
// with a 2-FF synchroniser, and a level interrupt gated by per-source enables.
module uart_periph #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);
  localparam logic [29:0] A_TXD = BASE_ADDR[31:2];
  localparam logic [29:0] A_RXD = A_TXD + 30'd1;
  localparam logic [29:0] A_CON = A_TXD + 30'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;

  ser_state_e    tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    txd_q, txd_d, rxd_q, rxd_d;
  logic          tx_q, tx_d, rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic          tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d;
  logic          rx_valid_q, rx_valid_d, tx_done_q, tx_done_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          irq_q, irq_d;
  logic          tx_start, tx_end, rx_good, rx_bad, tx_busy;
  logic [31:0]   con_val;

  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_bits;

  assign hit_txd = (addr[31:2] == A_TXD);
  assign hit_rxd = (addr[31:2] == A_RXD);
  assign hit_con = (addr[31:2] == A_CON);
  assign wr_txd  = MemWrite & hit_txd;
  assign wr_con  = MemWrite & hit_con;
  assign rd_rxd  = MemRead & hit_rxd;
  assign rd_con  = MemRead & hit_con;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign tx_busy = (tx_state_q != ST_IDLE);
  assign con_val = {25'b0, frame_err_q, overrun_q, tx_busy, tx_done_q,
                    rx_valid_q, rx_irq_en_q, tx_irq_en_q};

  // Reads always show pre-edge register state, even when a write lands in the same cycle.
  always_comb begin
    rdata = 32'b0;
    if (MemRead) begin
      if (hit_txd)      rdata = {24'b0, txd_q};
      else if (hit_rxd) rdata = {24'b0, rxd_q};
      else if (hit_con) rdata = con_val;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    txd_d      = txd_q;
    tx_start   = 1'b0;
    tx_end     = 1'b0;
    case (tx_state_q)
      ST_IDLE: tx_start = wr_txd;
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_end     = 1'b1;
          tx_state_d = ST_IDLE;
          tx_start   = wr_txd;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
    endcase
    // A write on the last stop clock chains straight into the next start bit.
    if (tx_start) begin
      tx_state_d = ST_START;
      tx_cnt_d   = '0;
      tx_d       = 1'b0;
      tx_shift_d = wdata[7:0];
      txd_d      = wdata[7:0];
    end
  end

  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_state_d = ST_IDLE;
          rx_good    = rx_s2_q;
          rx_bad     = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Flag updates: clears first, sets after, so a set in the same cycle wins.
  always_comb begin
    tx_irq_en_d = wr_con ? wdata[0] : tx_irq_en_q;
    rx_irq_en_d = wr_con ? wdata[1] : rx_irq_en_q;
    rxd_d       = rx_good ? rx_shift_q : rxd_q;
    tx_done_d   = tx_done_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_txd | rd_con) tx_done_d = 1'b0;
    if (rd_rxd)          rx_valid_d = 1'b0;
    if (rd_con) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (tx_end)                 tx_done_d   = 1'b1;
    if (rx_good)                rx_valid_d  = 1'b1;
    if (rx_good && rx_valid_q)  overrun_d   = 1'b1;
    if (rx_bad)                 frame_err_d = 1'b1;
    irq_d = (tx_irq_en_d & tx_done_d) | (rx_irq_en_d & rx_valid_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      tx_q        <= 1'b1;
      txd_q       <= 8'd0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rxd_q       <= 8'd0;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      txd_q       <= txd_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rxd_q       <= rxd_d;
      tx_irq_en_q <= tx_irq_en_d;
      rx_irq_en_q <= rx_irq_en_d;
      rx_valid_q  <= rx_valid_d;
      tx_done_q   <= tx_done_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_periph.sv
// Directed + randomized bench for uart_periph at DIV=16; a register-level model predicts
// CON/RXD/TXD/irq, and expected TX line levels are built from the frame layout.
module tb_uart_periph;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam int          DIV   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        MemWrite, MemRead, rx, tx, irq;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_en;
  logic       m_valid, m_ov, m_fe, m_done;
  logic [7:0] m_rxd, m_txd;
  logic [0:0] exp_q[$];

  logic [31:0] d;
  logic [7:0]  b;
  logic        good;

  always #5 clk = ~clk;

  uart_periph #(.CLK_HZ(1_600_000), .BAUD(100_000), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .MemWrite(MemWrite),
    .MemRead(MemRead), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] con_exp(input logic busy);
    return {25'b0, m_fe, m_ov, busy, m_done, m_valid, m_en};
  endfunction

  function automatic logic irq_exp();
    return (m_en[0] & m_done) | (m_en[1] & m_valid);
  endfunction

  task automatic model_reset();
    m_en = 2'b0; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_done = 1'b0;
    m_rxd = 8'd0; m_txd = 8'd0;
  endtask

  // All bus tasks start just after a negedge and return just after the next one.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    addr = a; wdata = v; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; MemRead = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] w, output logic [31:0] v);
    addr = a; wdata = w; MemRead = 1'b1; MemWrite = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_con(input string tag, input logic busy);
    logic [31:0] v;
    bus_read(A_CON, v);
    chk(tag, v, con_exp(busy));
    m_done = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic read_rxd(input string tag);
    logic [31:0] v;
    bus_read(A_RXD, v);
    chk(tag, v, {24'b0, m_rxd});
    m_valid = 1'b0;
  endtask

  task automatic write_con(input logic [1:0] v);
    bus_write(A_CON, {30'b0, v});
    m_en = v;
  endtask

  task automatic start_tx(input logic [7:0] v);
    bus_write(A_TXD, {24'b0, v});
    m_txd = v; m_done = 1'b0;
  endtask

  // Drive one 8N1 frame on rx, then update the model with the expected outcome.
  task automatic send_rx(input logic [7:0] v, input logic stop);
    rx = 1'b0; idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = v[i]; idle(DIV);
    end
    rx = stop; idle(DIV);
    rx = 1'b1;
    if (stop) begin
      if (m_valid) m_ov = 1'b1;
      m_valid = 1'b1;
      m_rxd = v;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  // Checks the whole tx waveform of a frame already started; optional ignored write
  // mid-frame and an optional chained write on the final stop clock.
  task automatic tx_frame(input logic [7:0] v, input logic poke, input logic chain,
                          input logic [7:0] nb);
    logic [0:0] lvl;
    for (int i = 0; i < 10; i++) begin
      lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : v[i-1];
      repeat (DIV) exp_q.push_back(lvl);
    end
    for (int k = 0; k < 10 * DIV; k++) begin
      lvl = exp_q.pop_front();
      chk($sformatf("tx_bit k=%0d byte=%h", k, v), {31'b0, tx}, {31'b0, lvl});
      if ((poke && k == 40) || (chain && k == 10 * DIV - 1)) begin
        addr = A_TXD;
        wdata = (k == 40) ? 32'hFF : {24'b0, nb};
        MemWrite = 1'b1;
      end
      @(negedge clk);
      MemWrite = 1'b0;
    end
    m_done = 1'b1;
    if (chain) m_txd = nb;
  endtask

  initial begin
    rst_n = 1'b0; addr = 32'b0; wdata = 32'b0; MemWrite = 1'b0; MemRead = 1'b0; rx = 1'b1;
    model_reset();
    idle(3);
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    read_con("reset_con", 1'b0);
    bus_read(A_TXD, d); chk("reset_txd", d, 32'd0);
    read_rxd("reset_rxd");
    addr = A_TXD; #1 chk("rdata_no_read", rdata, 32'd0);
    idle(1);

    // TX 0xA5 with exact bit timing, tx_done at clock 160.
    start_tx(8'hA5);
    tx_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    read_con("tx_done_set", 1'b0);
    read_con("tx_done_cleared", 1'b0);
    bus_read(A_TXD, d); chk("txd_readback", d, {24'b0, m_txd});

    // RX 0x3C with rx irq enabled.
    write_con(2'b10);
    send_rx(8'h3C, 1'b1);
    idle(DIV);
    chk("rx_irq_on", {31'b0, irq}, {31'b0, irq_exp()});
    read_con("rx_valid_set", 1'b0);
    chk("rx_irq_after_con", {31'b0, irq}, {31'b0, irq_exp()});
    read_rxd("rxd_3c");
    chk("rx_irq_off", {31'b0, irq}, {31'b0, irq_exp()});
    read_con("rx_valid_cleared", 1'b0);

    // Overrun: newest byte wins, CON read clears the flag.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    idle(DIV);
    read_rxd("rxd_overrun");
    read_con("overrun_set", 1'b0);
    read_con("overrun_cleared", 1'b0);

    // Glitch rejected; bad stop bit reports frame_err without rx_valid.
    rx = 1'b0; idle(5); rx = 1'b1; idle(30);
    read_con("glitch_no_flag", 1'b0);
    send_rx(8'h5A, 1'b0);
    idle(DIV);
    read_con("frame_err_set", 1'b0);
    chk("frame_err_no_irq", {31'b0, irq}, {31'b0, irq_exp()});

    // Busy write ignored, then back-to-back chained frame with no idle gap.
    start_tx(8'h55);
    tx_frame(8'h55, 1'b1, 1'b1, 8'hFF);
    tx_frame(8'hFF, 1'b0, 1'b0, 8'h00);
    bus_read(A_TXD, d); chk("txd_chained", d, {24'b0, m_txd});
    read_con("tx_done_chained", 1'b0);

    // tx_busy visible while a frame is in flight.
    start_tx(8'($urandom_range(0, 255)));
    read_con("tx_busy", 1'b1);
    idle(10 * DIV + 8);
    m_done = 1'b1;
    read_con("tx_busy_done", 1'b0);

    // Same-cycle read and write of CON: rdata is pre-write, write takes effect.
    bus_rw(A_CON, 32'h1, d);
    chk("con_rw_old", d, con_exp(1'b0));
    m_done = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_en = 2'b01;
    read_con("con_rw_new", 1'b0);
    bus_read(A_CON + 32'h4, d); chk("unmapped_read", d, 32'd0);

    // Random TX frames with tx irq enabled.
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      start_tx(b);
      tx_frame(b, 1'b0, 1'b0, 8'h00);
      chk("tx_irq_on", {31'b0, irq}, {31'b0, irq_exp()});
      read_con("tx_rand_con", 1'b0);
      chk("tx_irq_off", {31'b0, irq}, {31'b0, irq_exp()});
    end

    // Random RX frames, random stop validity and random read pattern.
    write_con(2'b11);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_rx(b, good);
      idle(DIV);
      chk("rx_rand_irq", {31'b0, irq}, {31'b0, irq_exp()});
      if ($urandom_range(0, 1) == 1) read_rxd("rx_rand_rxd");
      read_con("rx_rand_con", 1'b0);
      chk("rx_rand_irq_after", {31'b0, irq}, {31'b0, irq_exp()});
    end

    // Reset at clock 70 of a TX frame, with irq pending.
    send_rx(8'h77, 1'b1);
    idle(DIV);
    chk("pre_reset_irq", {31'b0, irq}, {31'b0, irq_exp()});
    start_tx(8'hC3);
    idle(70);
    chk("pre_reset_tx", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    idle(1);
    chk("reset_mid_tx", {31'b0, tx}, 32'd1);
    rst_n = 1'b1;
    model_reset();
    chk("reset_mid_irq", {31'b0, irq}, 32'd0);
    read_con("reset_mid_con", 1'b0);
    read_rxd("reset_mid_rxd");
    idle(4);
    chk("reset_tx_idle", {31'b0, tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
